arilla_bus_arbiter: RTL and testbench
=====================================

# arilla_bus_arbiter

Parametrised N-master arbiter that multiplexes several arilla bus masters (core fetch, core load/store, debug module, ...) onto a single arilla slave bus. Grants are round-robin and held for the whole transfer. The arbiter also watchdogs each transfer: an unclaimed address or a slave that never responds ends the transfer with an error instead of hanging the system. It sits between the masters and the address decoder/slave fabric.

## Interface
- Masters, 2: number of master ports, ≥2.
- DataWidth, 32: data width in bits, multiple of 8.
- AddressWidth, 32: byte address width; word address width AW = AddressWidth − $clog2(DataWidth/8); BE = DataWidth/8.
- TimeoutCycles, 16: maximum BUSY cycles per transfer; 0 disables the timeout.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- m_read, m_write  in  Masters  per-master request strobes.
- m_address  in  Masters*AW  per-master word address, master i at slice [i*AW +: AW].
- m_byte_enable  in  Masters*BE  per-master byte enables.
- m_wdata  in  Masters*DataWidth  per-master write data.
- m_rdata  out  DataWidth  read data, shared by all masters, valid only with that master's m_available.
- m_available  out  Masters  per-master completion strobe.
- m_error  out  Masters  per-master error flag, valid with m_available.
- s_read, s_write  out  1  slave strobes.
- s_address  out  AW; s_byte_enable  out  BE; s_wdata  out  DataWidth.
- s_rdata  in  DataWidth; s_available  in  1 (slave completes); s_intercept  in  1 (some slave claims s_address).

## Operation
- Master protocol: the master raises read or write and holds address, byte_enable and wdata stable until the cycle its m_available is high. If both read and write are high, the request is a write.
- Arbiter state: FSM {IDLE, BUSY}, registered grant index g, last-grant pointer p, timeout counter cnt of width $clog2(TimeoutCycles+1).
- IDLE: request vector r = m_read | m_write. If r ≠ 0, select the first requesting index searching p+1, p+2, … modulo Masters. Register it in g and p, clear cnt, and go to BUSY. While in IDLE, all s_* strobes are 0.
- BUSY: s_read/s_write/s_address/s_byte_enable/s_wdata are driven combinationally from master g, with s_read forced to 0 if m_write[g]. m_rdata = s_rdata.
- BUSY, normal completion: s_available=1 and s_intercept=1 → m_available[g]=1, m_error[g]=0, next state IDLE.
- BUSY, unclaimed address: s_intercept=0 → m_available[g]=1, m_error[g]=1, m_rdata all-ones, next state IDLE. Any s_available in that cycle is ignored.
- BUSY, timeout: TimeoutCycles≠0, cnt==TimeoutCycles−1 and no completion → same error response as an unclaimed address. Otherwise cnt increments each BUSY cycle.
- Mid-transfer drop: if master g drops both strobes in BUSY before completion (protocol violation), s strobes go 0, the FSM returns to IDLE next cycle, and no m_available is issued.
- Non-granted masters always see m_available=0 and m_error=0.

## Timing
- Reset (async assert, sync-free release): state=IDLE, g=0, p=Masters−1 (so master 0 wins first), cnt=0. All outputs 0 except m_rdata, which follows s_rdata combinationally.
- Reset asserted mid-transfer: the transfer is aborted immediately, with no completion strobe.
- Latency: request seen in IDLE at cycle 0 → bus driven in cycle 1. With a zero-wait slave, m_available is high in cycle 1. Cycle 2 is always IDLE (one-cycle bubble), so peak throughput is one transfer per 2 cycles.
- Completion outputs are combinational from s_available/s_intercept in the same BUSY cycle.
- Timeout error asserts in BUSY cycle number TimeoutCycles (1-based).
- Pointer wrap: p=Masters−1 searches from index 0.

## Test plan
- Single master 0 read, zero-wait slave with s_rdata=0xDEADBEEF → s_read high in cycle 1, m_available[0] and m_rdata=0xDEADBEEF in cycle 1, IDLE in cycle 2.
- Masters 0 and 1 requesting continuously, Masters=2 → grants alternate 0,1,0,1; each master completes once every 4 cycles.
- Master 1 write with s_intercept=0 → m_available[1]=1, m_error[1]=1 in the first BUSY cycle; the slave never sees a completed transfer.
- TimeoutCycles=4, slave claims but never sets available → m_error pulse in BUSY cycle 4, then IDLE; TimeoutCycles=0 waits indefinitely.
- Read and write both high from master 0 → s_write=1, s_read=0.
- rst_n pulled low in the second BUSY cycle → all s_* and m_available drop immediately; after release, master 0 wins first regardless of prior pointer.

Source files
------------

// File: rtl/arilla_bus_arbiter_if.sv
// Signal bundle around the arbiter: the per-master request lanes and the
// single shared slave bus.
interface arilla_bus_arbiter_if #(
  parameter int Masters      = 2,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
);
  localparam int BE = DataWidth / 8;
  localparam int AW = AddressWidth - $clog2(BE);

  logic [Masters-1:0]           m_read;
  logic [Masters-1:0]           m_write;
  logic [Masters*AW-1:0]        m_address;
  logic [Masters*BE-1:0]        m_byte_enable;
  logic [Masters*DataWidth-1:0] m_wdata;
  logic [DataWidth-1:0]         m_rdata;
  logic [Masters-1:0]           m_available;
  logic [Masters-1:0]           m_error;

  logic                         s_read;
  logic                         s_write;
  logic [AW-1:0]                s_address;
  logic [BE-1:0]                s_byte_enable;
  logic [DataWidth-1:0]         s_wdata;
  logic [DataWidth-1:0]         s_rdata;
  logic                         s_available;
  logic                         s_intercept;

  // master: the arbiter, which owns the shared bus; slave: the endpoints around it.
  modport master (
    input  m_read, m_write, m_address, m_byte_enable, m_wdata,
    input  s_rdata, s_available, s_intercept,
    output m_rdata, m_available, m_error,
    output s_read, s_write, s_address, s_byte_enable, s_wdata
  );

  modport slave (
    output m_read, m_write, m_address, m_byte_enable, m_wdata,
    output s_rdata, s_available, s_intercept,
    input  m_rdata, m_available, m_error,
    input  s_read, s_write, s_address, s_byte_enable, s_wdata
  );
endinterface

// File: rtl/arilla_bus_arbiter.sv
// Round-robin N-master arbiter onto one arilla slave bus, with grant held for
// the whole transfer and a watchdog that ends unclaimed or stalled transfers.
module arilla_bus_arbiter #(
  parameter int Masters       = 2,
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int TimeoutCycles = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  arilla_bus_arbiter_if.master bus
);
  localparam int BE = DataWidth / 8;
  localparam int AW = AddressWidth - $clog2(BE);
  localparam int GW = $clog2(Masters);
  localparam int CW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam bit TimeoutEn = (TimeoutCycles != 0);
  localparam logic [CW-1:0] CntLast = CW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                 state_q, state_d;
  logic [GW-1:0]          g_q, g_d;
  logic [GW-1:0]          p_q, p_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic [Masters-1:0]     req;
  logic [2*Masters-1:0]   req_rot;
  logic [GW-1:0]          sel;
  logic                   sel_vld;

  logic [Masters-1:0]     g_oh;
  logic                   g_rd;
  logic                   g_wr;
  logic [AW-1:0]          g_addr;
  logic [BE-1:0]          g_be;
  logic [DataWidth-1:0]   g_wdata;

  logic                   done_ok;
  logic                   done_err;

  assign req = bus.m_read | bus.m_write;

  // Rotate the doubled request vector so bit 0 is the master just after p.
  always_comb begin : rr_pick
    int pick;
    pick    = 0;
    sel     = '0;
    sel_vld = 1'b0;
    req_rot = {req, req} >> (int'(p_q) + 1);
    for (int i = 0; i < Masters; i++) begin
      if (!sel_vld && req_rot[i]) begin
        sel_vld = 1'b1;
        pick    = int'(p_q) + 1 + i;
        if (pick >= Masters) pick = pick - Masters;
        sel     = GW'(pick);
      end
    end
  end

  always_comb begin : grant_mux
    g_oh    = '0;
    g_rd    = 1'b0;
    g_wr    = 1'b0;
    g_addr  = '0;
    g_be    = '0;
    g_wdata = '0;
    for (int i = 0; i < Masters; i++) begin
      if (g_q == GW'(i)) begin
        g_oh[i] = 1'b1;
        g_rd    = bus.m_read[i];
        g_wr    = bus.m_write[i];
        g_addr  = bus.m_address[i*AW +: AW];
        g_be    = bus.m_byte_enable[i*BE +: BE];
        g_wdata = bus.m_wdata[i*DataWidth +: DataWidth];
      end
    end
  end

  always_comb begin : fsm_comb
    state_d           = state_q;
    g_d               = g_q;
    p_d               = p_q;
    cnt_d             = cnt_q;
    done_ok           = 1'b0;
    done_err          = 1'b0;
    bus.s_read        = 1'b0;
    bus.s_write       = 1'b0;
    bus.s_address     = '0;
    bus.s_byte_enable = '0;
    bus.s_wdata       = '0;
    bus.m_available   = '0;
    bus.m_error       = '0;
    bus.m_rdata       = bus.s_rdata;

    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          g_d     = sel;
          p_d     = sel;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A granted master that lets go mid-transfer is simply released.
        if (!(g_rd || g_wr)) begin
          state_d = IDLE;
        end else begin
          bus.s_write       = g_wr;
          bus.s_read        = g_rd & ~g_wr;
          bus.s_address     = g_addr;
          bus.s_byte_enable = g_be;
          bus.s_wdata       = g_wdata;
          if (!bus.s_intercept) begin
            done_err = 1'b1;
          end else if (bus.s_available) begin
            done_ok = 1'b1;
          end else if (TimeoutEn && (cnt_q == CntLast)) begin
            done_err = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        if (done_ok || done_err) begin
          bus.m_available = g_oh;
          state_d         = IDLE;
        end
        if (done_err) begin
          bus.m_error = g_oh;
          bus.m_rdata = '1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      g_q     <= '0;
      p_q     <= GW'(Masters - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_arilla_bus_arbiter.sv
// Bench for arilla_bus_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of the arbitration rules.
module tb_arilla_bus_arbiter;
  localparam int M   = 2;
  localparam int DW  = 32;
  localparam int ADW = 32;
  localparam int BE  = DW / 8;
  localparam int AW  = ADW - $clog2(BE);
  localparam int TO  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  arilla_bus_arbiter_if #(.Masters(M), .DataWidth(DW), .AddressWidth(ADW)) bus ();
  arilla_bus_arbiter_if #(.Masters(M), .DataWidth(DW), .AddressWidth(ADW)) bus0 ();

  arilla_bus_arbiter #(.Masters(M), .DataWidth(DW), .AddressWidth(ADW), .TimeoutCycles(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  arilla_bus_arbiter #(.Masters(M), .DataWidth(DW), .AddressWidth(ADW), .TimeoutCycles(0)) dut_nt (
    .clk(clk), .rst_n(rst_n), .bus(bus0));

  logic          mrd   [M];
  logic          mwr   [M];
  logic [AW-1:0] maddr [M];
  logic [BE-1:0] mbe   [M];
  logic [DW-1:0] mwd   [M];

  always_comb begin
    for (int i = 0; i < M; i++) begin
      bus.m_read[i]                   = mrd[i];
      bus.m_write[i]                  = mwr[i];
      bus.m_address[i*AW +: AW]       = maddr[i];
      bus.m_byte_enable[i*BE +: BE]   = mbe[i];
      bus.m_wdata[i*DW +: DW]         = mwd[i];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic clear_inputs();
    for (int i = 0; i < M; i++) begin
      mrd[i] = 1'b0; mwr[i] = 1'b0; maddr[i] = '0; mbe[i] = '0; mwd[i] = '0;
    end
    bus.s_rdata = '0; bus.s_available = 1'b0; bus.s_intercept = 1'b1;
    bus0.m_read = '0; bus0.m_write = '0; bus0.m_address = '0;
    bus0.m_byte_enable = '0; bus0.m_wdata = '0;
    bus0.s_rdata = '0; bus0.s_available = 1'b0; bus0.s_intercept = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    mrd[0] = 1'b1; mwr[1] = 1'b1;
    bus.s_rdata = 32'h1234_5678; bus.s_available = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.s_read, bus.s_write, bus.s_address, bus.s_byte_enable, bus.s_wdata} !== '0)
      $display("FAIL reset_sbus: got r=%b w=%b a=%h want all zero", bus.s_read, bus.s_write, bus.s_address);
    else n_pass++;
    n_checks++;
    if ({bus.m_available, bus.m_error} !== '0)
      $display("FAIL reset_mresp: got av=%b err=%b want 00 00", bus.m_available, bus.m_error);
    else n_pass++;
    n_checks++;
    if (bus.m_rdata !== 32'h1234_5678)
      $display("FAIL reset_rdata: got %h want 12345678", bus.m_rdata);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    next_cycle();
    mrd[0] = 1'b1; maddr[0] = 30'h123; mbe[0] = 4'hF;
    bus.s_rdata = 32'hDEAD_BEEF; bus.s_available = 1'b1; bus.s_intercept = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.s_read !== 1'b0 || bus.m_available !== 2'b00)
      $display("FAIL rd_cycle0: got s_read=%b av=%b want 0 00", bus.s_read, bus.m_available);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (bus.s_read !== 1'b1 || bus.s_address !== 30'h123 || bus.s_byte_enable !== 4'hF)
      $display("FAIL rd_cycle1_bus: got r=%b a=%h be=%h want 1 123 f", bus.s_read, bus.s_address, bus.s_byte_enable);
    else n_pass++;
    n_checks++;
    if (bus.m_available !== 2'b01 || bus.m_error !== 2'b00 || bus.m_rdata !== 32'hDEAD_BEEF)
      $display("FAIL rd_cycle1_resp: got av=%b err=%b d=%h want 01 00 deadbeef", bus.m_available, bus.m_error, bus.m_rdata);
    else n_pass++;
    next_cycle();
    maddr[0] = 30'h124;
    @(negedge clk);
    n_checks++;
    if (bus.s_read !== 1'b0 || bus.m_available !== 2'b00)
      $display("FAIL rd_bubble: got s_read=%b av=%b want 0 00", bus.s_read, bus.m_available);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (bus.s_read !== 1'b1 || bus.s_address !== 30'h124 || bus.m_available !== 2'b01)
      $display("FAIL rd_second: got r=%b a=%h av=%b want 1 124 01", bus.s_read, bus.s_address, bus.m_available);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [1:0]    exp_av [8];
    logic [AW-1:0] exp_a;
    exp_av = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    do_reset();
    next_cycle();
    mrd[0] = 1'b1; maddr[0] = 30'h0AA;
    mwr[1] = 1'b1; maddr[1] = 30'h0BB; mwd[1] = 32'hCAFE_0001; mbe[1] = 4'h3;
    bus.s_available = 1'b1; bus.s_intercept = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp_a = (exp_av[c] == 2'b01) ? 30'h0AA : (exp_av[c] == 2'b10) ? 30'h0BB : '0;
      n_checks++;
      if (bus.m_available !== exp_av[c] || bus.s_address !== exp_a)
        $display("FAIL rr_cycle%0d: got av=%b a=%h want %b %h", c, bus.m_available, bus.s_address, exp_av[c], exp_a);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_unclaimed();
    do_reset();
    next_cycle();
    mwr[1] = 1'b1; maddr[1] = 30'h3F0; mwd[1] = 32'h0BAD_F00D; mbe[1] = 4'hC;
    bus.s_intercept = 1'b0; bus.s_available = 1'b1; bus.s_rdata = 32'h5555_AAAA;
    @(negedge clk);
    n_checks++;
    if (bus.m_available !== 2'b00 || bus.s_write !== 1'b0)
      $display("FAIL unc_cycle0: got av=%b w=%b want 00 0", bus.m_available, bus.s_write);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (bus.m_available !== 2'b10 || bus.m_error !== 2'b10 || bus.m_rdata !== 32'hFFFF_FFFF)
      $display("FAIL unc_resp: got av=%b err=%b d=%h want 10 10 ffffffff", bus.m_available, bus.m_error, bus.m_rdata);
    else n_pass++;
    n_checks++;
    if (bus.s_write !== 1'b1 || bus.s_read !== 1'b0 || bus.s_wdata !== 32'h0BAD_F00D)
      $display("FAIL unc_bus: got w=%b r=%b wd=%h want 1 0 0badf00d", bus.s_write, bus.s_read, bus.s_wdata);
    else n_pass++;
    next_cycle();
    mwr[1] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.s_write !== 1'b0 || bus.m_available !== 2'b00)
      $display("FAIL unc_after: got w=%b av=%b want 0 00", bus.s_write, bus.m_available);
    else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    next_cycle();
    mrd[0] = 1'b1; maddr[0] = 30'h010;
    bus.s_intercept = 1'b1; bus.s_available = 1'b0; bus.s_rdata = 32'h0;
    @(negedge clk);
    for (int c = 1; c < TO; c++) begin
      next_cycle();
      @(negedge clk);
      n_checks++;
      if (bus.m_available !== 2'b00 || bus.s_read !== 1'b1)
        $display("FAIL to_wait%0d: got av=%b r=%b want 00 1", c, bus.m_available, bus.s_read);
      else n_pass++;
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (bus.m_available !== 2'b01 || bus.m_error !== 2'b01 || bus.m_rdata !== 32'hFFFF_FFFF)
      $display("FAIL to_fire: got av=%b err=%b d=%h want 01 01 ffffffff", bus.m_available, bus.m_error, bus.m_rdata);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (bus.s_read !== 1'b0 || bus.m_available !== 2'b00)
      $display("FAIL to_idle: got r=%b av=%b want 0 00", bus.s_read, bus.m_available);
    else n_pass++;
  endtask

  task automatic test_no_timeout();
    int seen;
    seen = 0;
    do_reset();
    next_cycle();
    bus0.m_read = 2'b01; bus0.m_address = {30'h0, 30'h077};
    bus0.s_intercept = 1'b1; bus0.s_available = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus0.m_available !== 2'b00) seen++;
      next_cycle();
    end
    n_checks++;
    if (seen != 0 || bus0.s_read !== 1'b1)
      $display("FAIL nto_wait: got completions=%0d r=%b want 0 1", seen, bus0.s_read);
    else n_pass++;
    bus0.s_available = 1'b1; bus0.s_rdata = 32'h0000_7777;
    @(negedge clk);
    n_checks++;
    if (bus0.m_available !== 2'b01 || bus0.m_error !== 2'b00 || bus0.m_rdata !== 32'h0000_7777)
      $display("FAIL nto_done: got av=%b err=%b d=%h want 01 00 00007777", bus0.m_available, bus0.m_error, bus0.m_rdata);
    else n_pass++;
  endtask

  task automatic test_rw_both();
    do_reset();
    next_cycle();
    mrd[0] = 1'b1; mwr[0] = 1'b1; maddr[0] = 30'h055; mwd[0] = 32'h1111_2222;
    bus.s_available = 1'b1; bus.s_intercept = 1'b1;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (bus.s_write !== 1'b1 || bus.s_read !== 1'b0 || bus.m_available !== 2'b01)
      $display("FAIL rw_both: got w=%b r=%b av=%b want 1 0 01", bus.s_write, bus.s_read, bus.m_available);
    else n_pass++;
  endtask

  task automatic test_drop();
    do_reset();
    next_cycle();
    mrd[0] = 1'b1; maddr[0] = 30'h099;
    bus.s_intercept = 1'b1; bus.s_available = 1'b0;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (bus.s_read !== 1'b1)
      $display("FAIL drop_busy: got r=%b want 1", bus.s_read);
    else n_pass++;
    next_cycle();
    mrd[0] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.s_read !== 1'b0 || bus.m_available !== 2'b00 || bus.m_error !== 2'b00)
      $display("FAIL drop_cut: got r=%b av=%b err=%b want 0 00 00", bus.s_read, bus.m_available, bus.m_error);
    else n_pass++;
    next_cycle();
    mrd[0] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.s_read !== 1'b0)
      $display("FAIL drop_idle: got r=%b want 0", bus.s_read);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (bus.s_read !== 1'b1)
      $display("FAIL drop_regrant: got r=%b want 1", bus.s_read);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    next_cycle();
    mrd[0] = 1'b1; maddr[0] = 30'h0A0;
    bus.s_intercept = 1'b1; bus.s_available = 1'b0;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (bus.s_read !== 1'b1 || bus.s_address !== 30'h0A0)
      $display("FAIL rmid_busy: got r=%b a=%h want 1 0a0", bus.s_read, bus.s_address);
    else n_pass++;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.s_read !== 1'b0 || bus.s_address !== '0 || bus.m_available !== 2'b00)
      $display("FAIL rmid_abort: got r=%b a=%h av=%b want 0 0 00", bus.s_read, bus.s_address, bus.m_available);
    else n_pass++;
    mrd[1] = 1'b1; maddr[1] = 30'h0B0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.s_read !== 1'b1 || bus.s_address !== 30'h0A0)
      $display("FAIL rmid_first: got r=%b a=%h want 1 0a0", bus.s_read, bus.s_address);
    else n_pass++;
  endtask

  // Transaction-level model: who owns the bus, who went last, how long it has waited.
  task automatic test_random(input int cycles);
    logic          active [M];
    logic          done_prev [M];
    bit            busy;
    int            owner, last, waited, kind;
    bit            found, fin_ok, fin_err;
    logic          s_av, s_int;
    logic [DW-1:0] s_rd;
    logic          e_sr, e_sw;
    logic [AW-1:0] e_sa;
    logic [BE-1:0] e_sbe;
    logic [DW-1:0] e_swd, e_rd;
    logic [M-1:0]  e_av, e_er, oh;
    do_reset();
    for (int i = 0; i < M; i++) begin active[i] = 1'b0; done_prev[i] = 1'b0; end
    busy = 1'b0; owner = 0; last = M - 1; waited = 0;
    for (int c = 0; c < cycles; c++) begin
      next_cycle();
      for (int i = 0; i < M; i++) begin
        if (done_prev[i]) begin
          mrd[i] = 1'b0; mwr[i] = 1'b0; active[i] = 1'b0; done_prev[i] = 1'b0;
        end
        if (!active[i] && $urandom_range(0, 2) == 0) begin
          kind = $urandom_range(0, 2);
          mrd[i] = (kind != 1); mwr[i] = (kind != 0);
          maddr[i] = AW'($urandom); mbe[i] = BE'($urandom); mwd[i] = $urandom;
          active[i] = 1'b1;
        end
      end
      s_av = ($urandom_range(0, 2) == 0);
      s_int = ($urandom_range(0, 9) != 0);
      s_rd = $urandom;
      bus.s_available = s_av; bus.s_intercept = s_int; bus.s_rdata = s_rd;
      @(negedge clk);
      e_sr = 1'b0; e_sw = 1'b0; e_sa = '0; e_sbe = '0; e_swd = '0;
      e_av = '0; e_er = '0; e_rd = s_rd; fin_ok = 1'b0; fin_err = 1'b0;
      if (busy) begin
        oh = {{(M-1){1'b0}}, 1'b1} << owner;
        e_sw = mwr[owner]; e_sr = mrd[owner] & ~mwr[owner];
        e_sa = maddr[owner]; e_sbe = mbe[owner]; e_swd = mwd[owner];
        waited++;
        if (!s_int) fin_err = 1'b1;
        else if (s_av) fin_ok = 1'b1;
        else if (waited == TO) fin_err = 1'b1;
        if (fin_ok || fin_err) begin
          e_av = oh; busy = 1'b0; done_prev[owner] = 1'b1;
        end
        if (fin_err) begin e_er = oh; e_rd = '1; end
      end else begin
        found = 1'b0;
        for (int k = 1; k <= M; k++) begin
          if (!found && (mrd[(last + k) % M] || mwr[(last + k) % M])) begin
            owner = (last + k) % M; found = 1'b1;
          end
        end
        if (found) begin busy = 1'b1; last = owner; waited = 0; end
      end
      n_checks++;
      if ({bus.s_read, bus.s_write, bus.s_address, bus.s_byte_enable, bus.s_wdata} !== {e_sr, e_sw, e_sa, e_sbe, e_swd})
        $display("FAIL rand_sbus@%0d: got r=%b w=%b a=%h be=%h wd=%h want %b %b %h %h %h", c,
                 bus.s_read, bus.s_write, bus.s_address, bus.s_byte_enable, bus.s_wdata, e_sr, e_sw, e_sa, e_sbe, e_swd);
      else n_pass++;
      n_checks++;
      if (bus.m_available !== e_av || bus.m_error !== e_er)
        $display("FAIL rand_resp@%0d: got av=%b err=%b want %b %b", c, bus.m_available, bus.m_error, e_av, e_er);
      else n_pass++;
      n_checks++;
      if (bus.m_rdata !== e_rd)
        $display("FAIL rand_rdata@%0d: got %h want %h", c, bus.m_rdata, e_rd);
      else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_unclaimed();
    test_timeout();
    test_no_timeout();
    test_rw_both();
    test_drop();
    test_reset_mid();
    test_random(400);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
